// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage: next-PC selection, IF/ID
// pipeline register and a saturating fetch counter for bring-up.
module fetch_unit #(
    parameter int              AW           = 32,
    parameter logic [AW-1:0]   RESET_VECTOR = '0,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [AW-1:0]    imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic [AW-1:0]    branch_pc4,
    input  logic             jump,
    input  logic [25:0]      jaddr,
    input  logic             jr,
    input  logic [AW-1:0]    jr_target,
    output logic [AW-1:0]    pc,
    output logic [31:0]      if_id_instr,
    output logic [AW-1:0]    if_id_pc4,
    output logic             if_id_valid,
    output logic             addr_err,
    output logic [CNT_W-1:0] fetch_count
);

    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] branch_offset;
    logic [AW-1:0] branch_dest;
    logic [AW-1:0] jump_dest;
    logic [AW-1:0] jr_dest;
    logic [AW-1:0] redirect_dest;
    logic          redirect;

    assign imem_addr = pc;

    // Every target is forced word-aligned, so the PC can never go misaligned.
    always_comb begin
        pc_plus4      = pc + AW'(4);
        branch_offset = {{(AW-18){branch_imm[15]}}, branch_imm, 2'b00};
        branch_dest   = branch_pc4 + branch_offset;
        jump_dest     = {branch_pc4[AW-1:28], jaddr, 2'b00};
        jr_dest       = {jr_target[AW-1:2], 2'b00};
        redirect      = jr | jump | branch_taken;
        if (jr)
            redirect_dest = jr_dest;
        else if (jump)
            redirect_dest = jump_dest;
        else
            redirect_dest = branch_dest;
    end

    // Redirects come from an older instruction in ID, so they beat stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            addr_err    <= 1'b0;
            fetch_count <= '0;
        end else begin
            addr_err <= jr && (jr_target[1:0] != 2'b00);
            if (redirect) begin
                pc          <= redirect_dest;
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                pc          <= pc_plus4;
                if_id_instr <= imem_data;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                if (fetch_count != {CNT_W{1'b1}})
                    fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default instance plus a CNT_W=2,
// RESET_VECTOR=0x00400000 instance driven by the same directed vectors.
module tb_fetch_unit;

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        bt;
        logic [15:0] imm;
        logic [31:0] bpc4;
        logic        jmp;
        logic [25:0] ja;
        logic        jrr;
        logic [31:0] jrt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic [15:0] cnt;
        logic [31:0] b_pc;
        logic [1:0]  b_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch_taken, jump, jr;
    logic [15:0] branch_imm;
    logic [31:0] branch_pc4, jr_target;
    logic [25:0] jaddr;

    logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc4;
    logic        if_id_valid, addr_err;
    logic [15:0] fetch_count;

    logic [31:0] b_imem_addr, b_imem_data, b_pc, b_if_id_instr, b_if_id_pc4;
    logic        b_if_id_valid, b_addr_err;
    logic [1:0]  b_fetch_count;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign imem_data   = {16'hC0DE, imem_addr[15:0]};
    assign b_imem_data = {16'hC0DE, b_imem_addr[15:0]};

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_imm(branch_imm),
        .branch_pc4(branch_pc4), .jump(jump), .jaddr(jaddr), .jr(jr),
        .jr_target(jr_target), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .addr_err(addr_err),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.AW(32), .RESET_VECTOR(32'h0040_0000), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .imem_addr(b_imem_addr), .imem_data(b_imem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_imm(branch_imm),
        .branch_pc4(branch_pc4), .jump(jump), .jaddr(jaddr), .jr(jr),
        .jr_target(jr_target), .pc(b_pc), .if_id_instr(b_if_id_instr),
        .if_id_pc4(b_if_id_pc4), .if_id_valid(b_if_id_valid), .addr_err(b_addr_err),
        .fetch_count(b_fetch_count)
    );

    task automatic checkOutput(input string name, input int step,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL step %0d %s: got 0x%08h, expected 0x%08h",
                     step, name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] p, input logic [31:0] ins,
                                   input logic [31:0] p4, input logic v, input logic e,
                                   input logic [15:0] c, input logic [31:0] bp,
                                   input logic [1:0] bc);
        exp_t x;
        x.pc = p; x.instr = ins; x.pc4 = p4; x.valid = v; x.err = e;
        x.cnt = c; x.b_pc = bp; x.b_cnt = bc;
        return x;
    endfunction

    // Drive one vector, let one edge happen, then queue what must be seen.
    task automatic applyStimulus(input stim_t s, input exp_t e);
        reset        = s.rst;
        stall        = s.stl;
        branch_taken = s.bt;
        branch_imm   = s.imm;
        branch_pc4   = s.bpc4;
        jump         = s.jmp;
        jaddr        = s.ja;
        jr           = s.jrr;
        jr_target    = s.jrt;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the queued expectation against both DUTs mid-cycle.
    int step = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("pc", step, pc, e.pc);
            checkOutput("imem_addr", step, imem_addr, e.pc);
            checkOutput("if_id_instr", step, if_id_instr, e.instr);
            checkOutput("if_id_pc4", step, if_id_pc4, e.pc4);
            checkOutput("if_id_valid", step, {31'd0, if_id_valid}, {31'd0, e.valid});
            checkOutput("addr_err", step, {31'd0, addr_err}, {31'd0, e.err});
            checkOutput("fetch_count", step, {16'd0, fetch_count}, {16'd0, e.cnt});
            checkOutput("b_pc", step, b_pc, e.b_pc);
            checkOutput("b_if_id_valid", step, {31'd0, b_if_id_valid}, {31'd0, e.valid});
            checkOutput("b_fetch_count", step, {30'd0, b_fetch_count}, {30'd0, e.b_cnt});
            step++;
        end
    end

    stim_t st;

    initial begin
        // S0: reset
        st = '0; st.rst = 1'b1;
        applyStimulus(st, mkExp(32'h0, 32'h0, 32'h0, 0, 0, 16'd0, 32'h0040_0000, 2'd0));
        // S1..S3: free-running fetch
        st = '0;
        applyStimulus(st, mkExp(32'h4, 32'hC0DE_0000, 32'h4, 1, 0, 16'd1, 32'h0040_0004, 2'd1));
        applyStimulus(st, mkExp(32'h8, 32'hC0DE_0004, 32'h8, 1, 0, 16'd2, 32'h0040_0008, 2'd2));
        applyStimulus(st, mkExp(32'hC, 32'hC0DE_0008, 32'hC, 1, 0, 16'd3, 32'h0040_000C, 2'd3));
        // S4: backward branch 0x10 + (-2 << 2) = 0x08
        st = '0; st.bt = 1'b1; st.bpc4 = 32'h10; st.imm = 16'hFFFE;
        applyStimulus(st, mkExp(32'h8, 32'h0, 32'hC, 0, 0, 16'd3, 32'h8, 2'd3));
        // S5: refetch at 0x08; B counter already saturated
        st = '0;
        applyStimulus(st, mkExp(32'hC, 32'hC0DE_0008, 32'hC, 1, 0, 16'd4, 32'hC, 2'd3));
        // S6: jump keeps upper nibble of branch_pc4
        st = '0; st.jmp = 1'b1; st.ja = 26'h0000040; st.bpc4 = 32'hA000_0010;
        applyStimulus(st, mkExp(32'hA000_0100, 32'h0, 32'hC, 0, 0, 16'd4, 32'hA000_0100, 2'd3));
        // S7: jr beats jump; misaligned target is aligned and flagged
        st.jrr = 1'b1; st.jrt = 32'h203;
        applyStimulus(st, mkExp(32'h200, 32'h0, 32'hC, 0, 1, 16'd4, 32'h200, 2'd3));
        // S8: addr_err drops after one cycle
        st = '0;
        applyStimulus(st, mkExp(32'h204, 32'hC0DE_0200, 32'h204, 1, 0, 16'd5, 32'h204, 2'd3));
        // S9..S11: stall freezes everything
        st = '0; st.stl = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(st, mkExp(32'h204, 32'hC0DE_0200, 32'h204, 1, 0, 16'd5, 32'h204, 2'd3));
        // S12: branch overrides stall
        st.bt = 1'b1; st.bpc4 = 32'h100; st.imm = 16'h0004;
        applyStimulus(st, mkExp(32'h110, 32'h0, 32'h204, 0, 0, 16'd5, 32'h110, 2'd3));
        // S13: aligned jr to top of address space, no error
        st = '0; st.jrr = 1'b1; st.jrt = 32'hFFFF_FFFC;
        applyStimulus(st, mkExp(32'hFFFF_FFFC, 32'h0, 32'h204, 0, 0, 16'd5, 32'hFFFF_FFFC, 2'd3));
        // S14: pc+4 wraps to zero
        st = '0;
        applyStimulus(st, mkExp(32'h0, 32'hC0DE_FFFC, 32'h0, 1, 0, 16'd6, 32'h0, 2'd3));
        // S15: stall hold
        st = '0; st.stl = 1'b1;
        applyStimulus(st, mkExp(32'h0, 32'hC0DE_FFFC, 32'h0, 1, 0, 16'd6, 32'h0, 2'd3));
        // S16: reset wins over stall, jump and misaligned jr
        st.rst = 1'b1; st.jmp = 1'b1; st.ja = 26'h155; st.jrr = 1'b1; st.jrt = 32'h203;
        applyStimulus(st, mkExp(32'h0, 32'h0, 32'h0, 0, 0, 16'd0, 32'h0040_0000, 2'd0));
        // S17: first fetch after reset comes from the reset vector
        st = '0;
        applyStimulus(st, mkExp(32'h4, 32'hC0DE_0000, 32'h4, 1, 0, 16'd1, 32'h0040_0004, 2'd1));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
